// File: rtl/mem_port_arbiter_if.sv
// Request/response channel between a memory requester and a memory target.
// A requester (cpu port, or the arbiter towards memory) uses master; a target uses slave.
interface mem_port_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        error;

    modport master (
        output req_valid, addr, wmask, wdata,
        input  req_ready, resp_valid, rdata, error
    );

    modport slave (
        input  req_valid, addr, wmask, wdata,
        output req_ready, resp_valid, rdata, error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter onto a single in-order memory port.
// An owner FIFO remembers which port issued each in-flight request so that responses route back.
module mem_port_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_port_arbiter_if.slave        port0,
    mem_port_arbiter_if.slave        port1,
    mem_port_arbiter_if.master       mem,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     protocol_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             last_grant;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] owner_q;

    logic full;
    logic gnt0;
    logic gnt1;
    logic push;
    logic pop;
    logic head_owner;

    // Port 1 wins when it is the only requester, or on a tie when port 0 was granted last.
    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        gnt1       = port1.req_valid & (~port0.req_valid | ~last_grant);
        gnt0       = port0.req_valid & ~gnt1;
        push       = (gnt0 | gnt1) & mem.req_ready & ~full;
        pop        = mem.resp_valid & (count != '0);
        head_owner = owner_q[rd_ptr];
    end

    assign mem.req_valid   = (port0.req_valid | port1.req_valid) & ~full;
    assign port0.req_ready = gnt0 & mem.req_ready & ~full;
    assign port1.req_ready = gnt1 & mem.req_ready & ~full;
    assign mem.addr        = gnt1 ? port1.addr  : port0.addr;
    assign mem.wmask       = gnt1 ? port1.wmask : port0.wmask;
    assign mem.wdata       = gnt1 ? port1.wdata : port0.wdata;
    assign outstanding     = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant   <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            owner_q      <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= gnt1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
                last_grant      <= gnt1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (mem.resp_valid && !pop) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // Response data/error hold their last value between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port0.resp_valid <= 1'b0;
            port0.rdata      <= '0;
            port0.error      <= 1'b0;
            port1.resp_valid <= 1'b0;
            port1.rdata      <= '0;
            port1.error      <= 1'b0;
        end else begin
            port0.resp_valid <= pop & ~head_owner;
            port1.resp_valid <= pop & head_owner;
            if (pop && !head_owner) begin
                port0.rdata <= mem.rdata;
                port0.error <= mem.error;
            end
            if (pop && head_owner) begin
                port1.rdata <= mem.rdata;
                port1.error <= mem.error;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (DEPTH=4): arbitration, routing, full, backpressure, reset.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] outstanding;
    logic protocol_err;
    int checks = 0;
    int failures = 0;

    mem_port_arbiter_if p0_if ();
    mem_port_arbiter_if p1_if ();
    mem_port_arbiter_if mem_if ();

    mem_port_arbiter #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .port0        (p0_if),
        .port1        (p1_if),
        .mem          (mem_if),
        .outstanding  (outstanding),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        p0_if.req_valid = 1'b0; p0_if.addr = '0; p0_if.wmask = '0; p0_if.wdata = '0;
        p1_if.req_valid = 1'b0; p1_if.addr = '0; p1_if.wmask = '0; p1_if.wdata = '0;
        mem_if.req_ready = 1'b0; mem_if.resp_valid = 1'b0; mem_if.rdata = '0; mem_if.error = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_resp0_valid", p0_if.resp_valid, 0);
        chk("rst_resp1_valid", p1_if.resp_valid, 0);
        chk("rst_resp0_rdata", p0_if.rdata, 0);
        chk("rst_mem_req_valid", mem_if.req_valid, 0);
        rst = 1'b1;

        // single read
        @(negedge clk);
        p0_if.req_valid = 1'b1; p0_if.addr = 30'h0400_0000; p0_if.wmask = 4'h0;
        mem_if.req_ready = 1'b1;
        #1;
        chk("rd_ready0", p0_if.req_ready, 1);
        chk("rd_ready1", p1_if.req_ready, 0);
        chk("rd_mem_valid", mem_if.req_valid, 1);
        chk("rd_mem_addr", mem_if.addr, 30'h0400_0000);
        @(negedge clk);
        p0_if.req_valid = 1'b0;
        chk("rd_outstanding", outstanding, 1);
        mem_if.resp_valid = 1'b1; mem_if.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_if.resp_valid = 1'b0; mem_if.rdata = 32'h0;
        chk("rd_resp0_valid", p0_if.resp_valid, 1);
        chk("rd_resp0_rdata", p0_if.rdata, 32'hDEAD_BEEF);
        chk("rd_resp1_valid", p1_if.resp_valid, 0);
        chk("rd_outstanding_done", outstanding, 0);
        @(negedge clk);
        chk("rd_resp0_pulse", p0_if.resp_valid, 0);
        chk("rd_resp0_hold", p0_if.rdata, 32'hDEAD_BEEF);

        // tie arbitration from a fresh reset: port 0 first, then alternating
        rst = 1'b0; #2; rst = 1'b1;
        p0_if.addr = 30'h100; p1_if.addr = 30'h200;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                if (((k - 2) % 2) == 0) begin
                    chk("tie_resp0_valid", p0_if.resp_valid, 1);
                    chk("tie_resp0_rdata", p0_if.rdata, 32'(k - 1));
                    chk("tie_resp1_idle", p1_if.resp_valid, 0);
                end else begin
                    chk("tie_resp1_valid", p1_if.resp_valid, 1);
                    chk("tie_resp1_rdata", p1_if.rdata, 32'(k - 1));
                    chk("tie_resp0_idle", p0_if.resp_valid, 0);
                end
            end
            p0_if.req_valid = (k < 6);
            p1_if.req_valid = (k < 6);
            mem_if.resp_valid = (k >= 1 && k <= 6);
            mem_if.rdata = 32'(k);
            #1;
            if (k < 6) begin
                chk("tie_ready0", p0_if.req_ready, ((k % 2) == 0) ? 1 : 0);
                chk("tie_ready1", p1_if.req_ready, ((k % 2) == 1) ? 1 : 0);
                chk("tie_mem_addr", mem_if.addr, ((k % 2) == 0) ? 30'h100 : 30'h200);
            end
        end
        chk("tie_outstanding", outstanding, 0);

        // fill to DEPTH with port 0 only
        p0_if.addr = 30'h300; p0_if.req_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("full_accept_ready0", p0_if.req_ready, 1);
            @(negedge clk);
            #1;
        end
        chk("full_outstanding", outstanding, 4);
        chk("full_mem_valid", mem_if.req_valid, 0);
        chk("full_ready0", p0_if.req_ready, 0);
        p1_if.req_valid = 1'b1;
        #1;
        chk("full_ready1", p1_if.req_ready, 0);
        p1_if.req_valid = 1'b0;
        mem_if.resp_valid = 1'b1; mem_if.rdata = 32'h55;
        #1;
        chk("full_push_blocked_on_pop", p0_if.req_ready, 0);
        @(negedge clk);
        mem_if.resp_valid = 1'b0;
        chk("full_after_pop", outstanding, 3);
        chk("full_resp0_rdata", p0_if.rdata, 32'h55);
        #1;
        chk("full_reaccept_ready0", p0_if.req_ready, 1);
        @(negedge clk);
        p0_if.req_valid = 1'b0;
        chk("full_refilled", outstanding, 4);

        // drain two back-to-back, then simultaneous push/pop at outstanding=2
        mem_if.resp_valid = 1'b1; mem_if.rdata = 32'h10;
        @(negedge clk);
        chk("b2b_resp0_a", p0_if.rdata, 32'h10);
        mem_if.rdata = 32'h11;
        @(negedge clk);
        chk("b2b_resp0_valid", p0_if.resp_valid, 1);
        chk("b2b_resp0_b", p0_if.rdata, 32'h11);
        chk("pp_outstanding_before", outstanding, 2);
        p1_if.req_valid = 1'b1; p1_if.addr = 30'h400;
        mem_if.rdata = 32'h12;
        #1;
        chk("pp_ready1", p1_if.req_ready, 1);
        @(negedge clk);
        p1_if.req_valid = 1'b0;
        chk("pp_outstanding_after", outstanding, 2);
        chk("pp_resp0_rdata", p0_if.rdata, 32'h12);
        chk("pp_resp1_idle", p1_if.resp_valid, 0);
        mem_if.rdata = 32'h13;
        @(negedge clk);
        chk("pp_order_port0", p0_if.resp_valid, 1);
        chk("pp_order_rdata0", p0_if.rdata, 32'h13);
        mem_if.rdata = 32'h14;
        @(negedge clk);
        mem_if.resp_valid = 1'b0;
        chk("pp_order_port1", p1_if.resp_valid, 1);
        chk("pp_order_rdata1", p1_if.rdata, 32'h14);
        chk("pp_order_port0_idle", p0_if.resp_valid, 0);
        chk("pp_drained", outstanding, 0);

        // backpressure on port 1
        mem_if.req_ready = 1'b0;
        p1_if.req_valid = 1'b1; p1_if.addr = 30'h123_4567; p1_if.wmask = 4'hF; p1_if.wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready1", p1_if.req_ready, 0);
            chk("bp_mem_valid", mem_if.req_valid, 1);
            chk("bp_mem_addr", mem_if.addr, 30'h123_4567);
            chk("bp_mem_wdata", mem_if.wdata, 32'hCAFE_F00D);
            chk("bp_mem_wmask", mem_if.wmask, 4'hF);
            @(negedge clk);
        end
        chk("bp_no_accept", outstanding, 0);
        mem_if.req_ready = 1'b1;
        #1;
        chk("bp_release_ready1", p1_if.req_ready, 1);
        @(negedge clk);
        p1_if.req_valid = 1'b0;
        chk("bp_single_accept", outstanding, 1);
        mem_if.resp_valid = 1'b1; mem_if.error = 1'b1; mem_if.rdata = 32'h0;
        @(negedge clk);
        mem_if.resp_valid = 1'b0; mem_if.error = 1'b0;
        chk("bp_resp1_valid", p1_if.resp_valid, 1);
        chk("bp_resp1_error", p1_if.error, 1);
        chk("bp_resp1_rdata", p1_if.rdata, 0);

        // spurious response
        @(negedge clk);
        mem_if.resp_valid = 1'b1;
        @(negedge clk);
        mem_if.resp_valid = 1'b0;
        chk("spur_protocol_err", protocol_err, 1);
        chk("spur_resp0_valid", p0_if.resp_valid, 0);
        chk("spur_resp1_valid", p1_if.resp_valid, 0);
        chk("spur_outstanding", outstanding, 0);

        // async reset mid-burst
        p0_if.req_valid = 1'b1; p0_if.addr = 30'h500;
        repeat (4) @(negedge clk);
        p0_if.req_valid = 1'b0;
        mem_if.resp_valid = 1'b1; mem_if.rdata = 32'h77;
        @(negedge clk);
        mem_if.resp_valid = 1'b0;
        chk("mid_outstanding", outstanding, 3);
        chk("mid_resp0_valid", p0_if.resp_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_outstanding", outstanding, 0);
        chk("arst_protocol_err", protocol_err, 0);
        chk("arst_resp0_valid", p0_if.resp_valid, 0);
        chk("arst_resp0_rdata", p0_if.rdata, 0);
        chk("arst_resp1_error", p1_if.error, 0);
        rst = 1'b1;

        // response after reset has no owner
        @(negedge clk);
        mem_if.resp_valid = 1'b1;
        @(negedge clk);
        mem_if.resp_valid = 1'b0;
        chk("post_rst_protocol_err", protocol_err, 1);
        chk("post_rst_resp0_valid", p0_if.resp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single core-side memory port (ROM/RAM/UART/tohost address space) between two requesters: port 0 (instruction fetch) and port 1 (load/store unit). Arbitrates round-robin on a valid/ready request channel, tracks up to DEPTH in-order outstanding transactions in an owner FIFO, and routes each memory response back to the port that issued it. Sits between the cpu front-end/LSQ and the memory model or bus.

## Interface
- DEPTH, 4, maximum outstanding transactions; power of two, 2..16
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- reqN_valid  in  1  port N (N=0,1) request valid
- reqN_ready  out  1  port N request accepted this cycle
- reqN_addr  in  30  port N word address [31:2]
- reqN_wmask  in  4  port N byte write mask; 0 = read
- reqN_wdata  in  32  port N write data
- respN_valid  out  1  port N response valid, one-cycle pulse
- respN_rdata  out  32  port N read data (0 for writes)
- respN_error  out  1  port N response error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  30  muxed word address
- mem_wmask  out  4  muxed write mask
- mem_wdata  out  32  muxed write data
- mem_resp_valid  in  1  memory response (no backpressure, in request order)
- mem_rdata  in  32  memory read data
- mem_error  in  1  memory response error
- outstanding  out  clog2(DEPTH)+1  number of in-flight transactions
- protocol_err  out  1  sticky: response received with no transaction in flight

## Operation
- full = (outstanding == DEPTH). mem_req_valid = (req0_valid | req1_valid) & ~full.
- Grant (combinational): only one valid -> that port; both valid -> port != last_grant. Grant gated by ~full.
- reqN_ready = grantN & mem_req_ready & ~full. mem_addr/wmask/wdata muxed from granted port; when no port valid, they drive port 0 fields.
- Accept (reqN_valid & reqN_ready): push N into owner FIFO, last_grant <= N.
- Requesters hold valid and payload stable until ready; arbiter never drops an unaccepted request. Grant may switch while mem_req_ready is low if a new port becomes valid (grant is re-evaluated every cycle).
- mem_resp_valid with FIFO non-empty: pop head owner H; next cycle respH_valid=1, respH_rdata=mem_rdata, respH_error=mem_error; other port's resp_valid=0.
- mem_resp_valid with FIFO empty: no pop, no response, protocol_err <= 1 (held until reset).
- Push and pop in same cycle: outstanding unchanged; FIFO pointers both advance. Push blocked when full even if a pop occurs that cycle.
- FIFO pointers clog2(DEPTH) bits, wrap modulo DEPTH.

## Timing
- Request path combinational: memory sees request the same cycle reqN_valid rises (if not full).
- Response latency: exactly 1 cycle from mem_resp_valid to respN_valid.
- Back-to-back responses sustained at one per cycle.
- Reset (asserted any time, including mid-transaction): outstanding=0, FIFO empty, last_grant=1 (port 0 wins first tie), resp0/1_valid=0, resp0/1_rdata=0, resp0/1_error=0, protocol_err=0. In-flight transactions are forgotten; responses arriving after reset with empty FIFO set protocol_err.
- resp rdata/error hold last value when resp_valid=0.

## Test plan
- Single read: req0 addr=0x04000000 wmask=0, mem_req_ready=1, mem_resp next cycle rdata=0xDEADBEEF -> req0_ready same cycle, resp0_valid one cycle after mem_resp_valid with 0xDEADBEEF, resp1_valid stays 0.
- Tie arbitration: both ports valid continuously, 6 requests accepted -> grant order 0,1,0,1,0,1; responses with rdata=1..6 routed alternately resp0,resp1.
- Full: DEPTH=4, mem_req_ready=1, no responses -> 4 accepts then mem_req_valid=0, reqN_ready=0, outstanding=4; one mem_resp -> outstanding=3 next cycle, one further accept allowed the cycle after.
- Simultaneous push/pop at outstanding=2 -> outstanding stays 2, correct owner order preserved.
- Backpressure: mem_req_ready=0 for 5 cycles with req1 valid -> no accept, req1 payload unchanged at mem_*; ready=1 -> single accept.
- Spurious response with outstanding=0 -> protocol_err=1, no respN_valid; async reset mid-burst (outstanding=3) -> all outputs reset values immediately, protocol_err=0.
